// File: rtl/sysbus_arbiter_pkg.sv
// sysbus_arbiter_pkg
// Shared types for the marvin system-bus arbiter slice.
//   SYSBUS_ADDR_W / SYSBUS_DATA_W : default bus widths
//   sysbus_cmd_t                  : one latched master command {we, addr, wdata}
//   sysbus_state_t                : arbiter FSM states
package sysbus_arbiter_pkg;

  localparam int SYSBUS_ADDR_W = 24;
  localparam int SYSBUS_DATA_W = 16;

  typedef struct packed {
    logic                     we;
    logic [SYSBUS_ADDR_W-1:0] addr;
    logic [SYSBUS_DATA_W-1:0] wdata;
  } sysbus_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_ACK   = 2'd3
  } sysbus_state_t;

endpackage

// File: rtl/sysbus_arbiter_if.sv
// sysbus_arbiter_if
// Bundles the master-facing and slave-facing bus signals of the arbiter.
//   m_req/m_we/m_addr/m_wdata : per-master command inputs
//   m_ack/m_err/m_rdata       : completion back to the masters
//   s_req/s_we/s_addr/s_wdata : command toward the single slave
//   s_gnt/s_rvalid/s_rdata    : slave handshake and read data
// Modport "master" is the arbiter's own view (it masters the slave bus);
// modport "slave" is the surrounding system's view (masters plus slave).
interface sysbus_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16
);

  logic [N_MASTERS-1:0]             m_req;
  logic [N_MASTERS-1:0]             m_we;
  logic [N_MASTERS-1:0][ADDR_W-1:0] m_addr;
  logic [N_MASTERS-1:0][DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]             m_ack;
  logic                             m_err;
  logic [DATA_W-1:0]                m_rdata;

  logic              s_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_gnt;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;

  modport master (
    input  m_req, m_we, m_addr, m_wdata, s_gnt, s_rvalid, s_rdata,
    output m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata
  );

  modport slave (
    output m_req, m_we, m_addr, m_wdata, s_gnt, s_rvalid, s_rdata,
    input  m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata
  );

endinterface

// File: rtl/sysbus_arbiter_rr.sv
// rr_arbiter
// Combinational round-robin picker.
//   req   : request vector, one bit per master
//   last  : index of the most recently served master
//   valid : any request present
//   idx   : first requester at or after last+1, wrapping modulo N
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
    int sum;
    sum = (base + off) % N;
    return IDX_W'(sum);
  endfunction

  // Walk offsets from the far end toward last+1 so the closest requester
  // is the final assignment and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[wrap_idx(int'(last), i)]) begin
        valid = 1'b1;
        idx   = wrap_idx(int'(last), i);
      end
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter
// N-master to 1-slave round-robin system-bus arbiter with per-transaction
// timeout. Each accepted command is latched, issued with s_req/s_gnt, and
// completed with a one-cycle one-hot m_ack (m_err flags a timeout).
//   clk  : system clock, rising edge
//   rst_ : asynchronous active-low reset
//   bus  : sysbus_arbiter_if.master, all master-side and slave-side signals
// Every output is a register, so nothing combinational reaches s_* from m_*.
module sysbus_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst_,
  sysbus_arbiter_if.master    bus
);

  import sysbus_arbiter_pkg::*;

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sysbus_state_t    state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last;
  logic [CNT_W-1:0] tcount;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             timed_out;

  rr_arbiter #(.N(N_MASTERS)) u_rr (
    .req   (bus.m_req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // tcount holds the number of ISSUE/RESP cycles already spent, so the
  // abort fires in the (TIMEOUT+1)-th such cycle.
  assign timed_out = (tcount == CNT_W'(TIMEOUT));

  // m_ack/m_err/m_rdata default to zero each cycle and are only loaded on
  // the transition into ACK, which makes them exactly one cycle wide.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state       <= ST_IDLE;
      owner       <= '0;
      last        <= IDX_W'(N_MASTERS - 1);
      tcount      <= '0;
      bus.m_ack   <= '0;
      bus.m_err   <= 1'b0;
      bus.m_rdata <= '0;
      bus.s_req   <= 1'b0;
      bus.s_we    <= 1'b0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
    end else begin
      bus.m_ack   <= '0;
      bus.m_err   <= 1'b0;
      bus.m_rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner       <= pick_idx;
            last        <= pick_idx;
            bus.s_we    <= bus.m_we[pick_idx];
            bus.s_addr  <= bus.m_addr[pick_idx];
            bus.s_wdata <= bus.m_wdata[pick_idx];
            bus.s_req   <= 1'b1;
            tcount      <= '0;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tcount <= tcount + 1'b1;
          if (timed_out) begin
            bus.s_req        <= 1'b0;
            bus.m_ack[owner] <= 1'b1;
            bus.m_err        <= 1'b1;
            state            <= ST_ACK;
          end else if (bus.s_gnt) begin
            bus.s_req <= 1'b0;
            if (bus.s_we) begin
              bus.m_ack[owner] <= 1'b1;
              state            <= ST_ACK;
            end else if (bus.s_rvalid) begin
              bus.m_rdata      <= bus.s_rdata;
              bus.m_ack[owner] <= 1'b1;
              state            <= ST_ACK;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          tcount <= tcount + 1'b1;
          if (timed_out) begin
            bus.m_ack[owner] <= 1'b1;
            bus.m_err        <= 1'b1;
            state            <= ST_ACK;
          end else if (bus.s_rvalid) begin
            bus.m_rdata      <= bus.s_rdata;
            bus.m_ack[owner] <= 1'b1;
            state            <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sysbus_arbiter.md
# sysbus_arbiter

Parametrised N-master to 1-slave system-bus arbiter for intermodular communication inside `marvin`. It sits between bus masters (CPU, VGA fetch, UART DMA) and a single slave port, typically the SDRAM controller or the peripheral decoder. Arbitration is round-robin. Each master command is latched, issued to the slave with a request/grant handshake, and completed with a one-cycle acknowledge. A per-transaction timeout returns an error response.

## Interface
- `N_MASTERS`, default 4: number of master ports, range 2..16.
- `ADDR_W`, default 24: address width.
- `DATA_W`, default 16: data width.
- `TIMEOUT`, default 255: maximum number of cycles spent in ISSUE plus RESP before the arbiter aborts the transaction.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_`  in  1  reset, asynchronous and active-low.
- `m_req`  in  N_MASTERS  per-master request; held until the master sees `m_ack`.
- `m_we`  in  N_MASTERS  per-master write enable: 1 = write, 0 = read.
- `m_addr`  in  N_MASTERS×ADDR_W  per-master address.
- `m_wdata`  in  N_MASTERS×DATA_W  per-master write data.
- `m_ack`  out  N_MASTERS  one-hot completion pulse to the owning master.
- `m_err`  out  1  high together with `m_ack` when the transaction timed out.
- `m_rdata`  out  DATA_W  read data, broadcast to all masters; valid while any `m_ack` bit is high.
- `s_req`  out  1  command valid toward the slave.
- `s_we`  out  1  slave write enable.
- `s_addr`  out  ADDR_W  slave address.
- `s_wdata`  out  DATA_W  slave write data.
- `s_gnt`  in  1  slave accepts the command in this cycle.
- `s_rvalid`  in  1  slave read data valid.
- `s_rdata`  in  DATA_W  slave read data.

## Operation
- FSM states: IDLE, ISSUE, RESP, ACK.
- IDLE:
  - If any `m_req` bit is high, select the first requester at or after `last+1`, wrapping modulo N_MASTERS.
  - Latch `owner`, `we`, `addr` and `wdata` into the slave registers.
  - Set `last` to `owner`, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - `s_req` is 1.
  - On `s_gnt`, a write goes to ACK.
  - On `s_gnt`, a read goes to RESP. If `s_rvalid` is also high in the same cycle, capture `s_rdata` and go directly to ACK.
- RESP: on `s_rvalid`, capture `s_rdata` into the rdata register and go to ACK. `s_req` is 0 in this state.
- ACK:
  - `m_ack[owner]` is 1 for exactly one cycle.
  - `m_rdata` is the captured data; it is `'0` after a write.
  - The next state is always IDLE.
- Timeout:
  - A counter clears on IDLE→ISSUE and increments in every ISSUE or RESP cycle.
  - When the count reaches TIMEOUT, go to ACK with `m_err` = 1 and `m_rdata` = `'0`.
  - `s_req` drops on the same transition.
- `m_err` is high only during an ACK that was reached by timeout.
- `s_rvalid` is ignored in IDLE and ACK, and in ISSUE unless `s_gnt` is high in the same cycle for a read.
- If a master drops `m_req` mid-transaction, the latched command still completes and `m_ack` is still pulsed.
- A master that keeps `m_req` high after its ACK is serviced again only after every other pending requester has been served.
- All slave-side and master-side outputs are registered or decoded only from the state; no combinational path runs from `m_*` inputs to `s_*` outputs.

## Timing
- Reset values:
  - state = IDLE.
  - `last` = N_MASTERS-1, so master 0 wins first.
  - `m_ack` = 0, `m_err` = 0, `m_rdata` = 0.
  - `s_req` = 0, `s_we` = 0, `s_addr` = 0, `s_wdata` = 0.
  - timeout counter = 0.
- Reset mid-transaction aborts the transaction immediately: no ack is issued and `s_req` drops asynchronously.
- Write with a zero-wait slave: `m_req` high in cycle 0, `s_req` in cycle 1, `s_gnt` in cycle 1, `m_ack` in cycle 2, back in IDLE in cycle 3. This gives 2-cycle latency and a 3-cycle back-to-back period.
- Read with `s_rvalid` k cycles after the `s_gnt` cycle: `m_ack` arrives in cycle 2+k.
- Timeout path: `m_ack` with `m_err` occurs TIMEOUT+1 cycles after the IDLE→ISSUE edge. The counter is width $clog2(TIMEOUT+1).

## Structure
- Shared package `pkg` holds:
  - `sysbus_cmd_t`, a packed struct {we, addr, wdata} sized by the package defaults `SYSBUS_ADDR_W` = 24 and `SYSBUS_DATA_W` = 16.
  - The FSM enum `sysbus_state_t`.
- Sub-module `rr_arbiter` is a combinational round-robin picker.
  - Parameter: N.
  - Inputs: `req[N]`, `last[$clog2(N)]`.
  - Outputs: `valid`, `idx`.
- `sysbus_arbiter` holds the FSM, the command/rdata registers and the timeout counter.

## Test plan
- Reset with `m_req` = 4'b1111 → masters served in order 0,1,2,3,0; exactly one `m_ack` bit per ACK.
- Master 2 writes addr 0x00_1234, data 0xBEEF, slave grants immediately → `s_addr`/`s_wdata` match in cycle 1, `m_ack` = 4'b0100 in cycle 2, `m_err` = 0.
- Master 1 reads, `s_gnt` in cycle 3, `s_rvalid` with 0xA5A5 in cycle 5 → `m_ack[1]` in cycle 6 with `m_rdata` = 0xA5A5.
- Slave never grants, TIMEOUT = 8 → `m_ack` with `m_err` = 1 and `m_rdata` = 0 nine cycles after issue; `s_req` low afterwards.
- Master 3 drops `m_req` after its command is latched → transaction completes and `m_ack[3]` still pulses.
- Assert `rst_` low during RESP → `s_req`/`m_ack` go to 0 asynchronously; after release master 0 wins first.
